cache_mem_arbiter: RTL and testbench

CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

---
 rtl/cache_mem_arbiter.sv | 132 +++++++++++++
 tb/tb_cache_mem_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter that shares one block RAM between an instruction cache
// and a data cache: one access at a time, fixed LATENCY cycles per access.
module cache_mem_arbiter #(
  parameter int WA             = 32,
  parameter int BLOCKSIZE      = 128,
  parameter int BYTE_ADDR_BITS = 4,
  parameter int LATENCY        = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_req,
  input  logic [WA-1:0]        i_addr,
  output logic                 i_ready,
  output logic [BLOCKSIZE-1:0] i_rdata,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [WA-1:0]        d_addr,
  input  logic [BLOCKSIZE-1:0] d_wdata,
  output logic                 d_ready,
  output logic [BLOCKSIZE-1:0] d_rdata,
  output logic                 BlockReadEnable,
  output logic                 BlockWriteEnable,
  output logic [WA-1:0]        BlockAddr,
  output logic [BLOCKSIZE-1:0] BlockDataIn,
  input  logic [BLOCKSIZE-1:0] BlockDataOut,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
  typedef enum logic {GRANT_I, GRANT_D} grant_e;

  localparam logic [WA-1:0] ALIGN_MASK = ~((WA'(1) << BYTE_ADDR_BITS) - WA'(1));
  localparam logic [3:0]    CNT_LOAD   = 4'(LATENCY - 1);

  state_e                 state_q, state_d;
  grant_e                 grant_q, grant_d;
  grant_e                 last_grant_q, last_grant_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   we_q, we_d;
  logic [WA-1:0]          addr_q, addr_d;
  logic [BLOCKSIZE-1:0]   wdata_q, wdata_d;
  logic [BLOCKSIZE-1:0]   i_rdata_q, i_rdata_d;
  logic [BLOCKSIZE-1:0]   d_rdata_q, d_rdata_d;

  always_comb begin
    // NOTE: every signal gets its hold value first so no path can infer a latch.
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          // On a tie the side that did not win last time goes first.
          if (d_req && (!i_req || last_grant_q == GRANT_I)) begin
            grant_d = GRANT_D;
            we_d    = d_we;
            addr_d  = d_addr & ALIGN_MASK;
            wdata_d = d_wdata;
          end else begin
            grant_d = GRANT_I;
            we_d    = 1'b0;
            addr_d  = i_addr & ALIGN_MASK;
            wdata_d = '0;
          end
          cnt_d   = CNT_LOAD;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          if (!we_q) begin
            if (grant_q == GRANT_D) d_rdata_d = BlockDataOut;
            else                    i_rdata_d = BlockDataOut;
          end
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        last_grant_d = grant_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the wide data registers are reset too, so rdata reads back as zero
  // after reset rather than stale RAM contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= GRANT_I;
      last_grant_q <= GRANT_I;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so all state updates on the same edge.
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign BlockReadEnable  = (state_q == ACCESS) && !we_q;
  assign BlockWriteEnable = (state_q == ACCESS) &&  we_q;
  assign BlockAddr        = addr_q;
  assign BlockDataIn      = wdata_q;
  assign i_ready          = (state_q == RESP) && (grant_q == GRANT_I);
  assign d_ready          = (state_q == RESP) && (grant_q == GRANT_D);
  assign i_rdata          = i_rdata_q;
  assign d_rdata          = d_rdata_q;
  assign busy             = (state_q != IDLE);

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: LATENCY=4 instance for the main
// scenarios plus a LATENCY=1 instance for the shortest access.
module tb_cache_mem_arbiter;

  localparam logic [127:0] DATA_A5 = {16{8'hA5}};
  localparam logic [127:0] DATA_5A = {16{8'h5A}};
  localparam logic [127:0] DATA_B7 = {16{8'hB7}};
  localparam logic [127:0] DATA_C3 = {16{8'hC3}};
  localparam logic [127:0] DATA_77 = {16{8'h77}};
  localparam logic [127:0] DATA_3C = {16{8'h3C}};
  localparam logic [127:0] WDATA   = 128'h00112233445566778899AABBCCDDEEFF;

  logic         clk = 1'b0;
  logic         rst;
  int           tests_run = 0;
  int           fails = 0;

  logic         i_req, d_req, d_we;
  logic [31:0]  i_addr, d_addr;
  logic [127:0] d_wdata, block_data_out;
  logic         i_ready, d_ready, bre, bwe, busy;
  logic [127:0] i_rdata, d_rdata, bdin;
  logic [31:0]  baddr;

  logic         l1_i_req;
  logic [31:0]  l1_i_addr;
  logic [127:0] l1_block_data_out;
  logic         l1_i_ready, l1_d_ready, l1_bre, l1_bwe, l1_busy;
  logic [127:0] l1_i_rdata, l1_d_rdata, l1_bdin;
  logic [31:0]  l1_baddr;

  always #5 clk = ~clk;

  cache_mem_arbiter #(.LATENCY(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .BlockReadEnable(bre), .BlockWriteEnable(bwe), .BlockAddr(baddr),
    .BlockDataIn(bdin), .BlockDataOut(block_data_out), .busy(busy)
  );

  cache_mem_arbiter #(.LATENCY(1)) dut_l1 (
    .clk(clk), .rst(rst),
    .i_req(l1_i_req), .i_addr(l1_i_addr), .i_ready(l1_i_ready), .i_rdata(l1_i_rdata),
    .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(128'h0),
    .d_ready(l1_d_ready), .d_rdata(l1_d_rdata),
    .BlockReadEnable(l1_bre), .BlockWriteEnable(l1_bwe), .BlockAddr(l1_baddr),
    .BlockDataIn(l1_bdin), .BlockDataOut(l1_block_data_out), .busy(l1_busy)
  );

  task automatic test_reset();
    #3;
    tests_run++;
    if (busy !== 1'b0 || bre !== 1'b0 || bwe !== 1'b0 || i_ready !== 1'b0 ||
        d_ready !== 1'b0 || baddr !== 32'h0 || bdin !== 128'h0 ||
        i_rdata !== 128'h0 || d_rdata !== 128'h0) begin
      fails++;
      $display("FAIL reset_state: busy=%b re=%b we=%b ir=%b dr=%b addr=%h want all 0",
               busy, bre, bwe, i_ready, d_ready, baddr);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || bre !== 1'b0 || bwe !== 1'b0 || i_ready !== 1'b0 || d_ready !== 1'b0) begin
      fails++;
      $display("FAIL idle_no_req: busy=%b re=%b we=%b ir=%b dr=%b want all 0",
               busy, bre, bwe, i_ready, d_ready);
    end
  endtask

  task automatic test_read();
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_1237; block_data_out = DATA_A5;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      tests_run++;
      if (bre !== 1'b1 || bwe !== 1'b0 || baddr !== 32'h0000_1230 || d_ready !== 1'b0 || busy !== 1'b1) begin
        fails++;
        $display("FAIL read_access cyc %0d: re=%b we=%b addr=%h dr=%b busy=%b want re=1 we=0 addr=00001230 dr=0 busy=1",
                 c, bre, bwe, baddr, d_ready, busy);
      end
    end
    @(negedge clk);
    tests_run++;
    if (d_ready !== 1'b1 || i_ready !== 1'b0 || bre !== 1'b0 || d_rdata !== DATA_A5) begin
      fails++;
      $display("FAIL read_resp: dr=%b ir=%b re=%b d_rdata=%h want dr=1 ir=0 re=0 d_rdata=%h",
               d_ready, i_ready, bre, d_rdata, DATA_A5);
    end
    d_req = 1'b0;
    @(negedge clk);
    tests_run++;
    if (d_ready !== 1'b0 || busy !== 1'b0 || d_rdata !== DATA_A5) begin
      fails++;
      $display("FAIL read_after: dr=%b busy=%b d_rdata=%h want dr=0 busy=0 d_rdata=%h",
               d_ready, busy, d_rdata, DATA_A5);
    end
  endtask

  task automatic test_write();
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_2000; d_wdata = WDATA; block_data_out = DATA_5A;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      tests_run++;
      if (bwe !== 1'b1 || bre !== 1'b0 || bdin !== WDATA || baddr !== 32'h0000_2000 || d_ready !== 1'b0) begin
        fails++;
        $display("FAIL write_access cyc %0d: we=%b re=%b din=%h addr=%h dr=%b want we=1 re=0 din=%h addr=00002000 dr=0",
                 c, bwe, bre, bdin, baddr, d_ready, WDATA);
      end
    end
    @(negedge clk);
    tests_run++;
    if (d_ready !== 1'b1 || bwe !== 1'b0 || d_rdata !== DATA_A5) begin
      fails++;
      $display("FAIL write_resp: dr=%b we=%b d_rdata=%h want dr=1 we=0 d_rdata=%h",
               d_ready, bwe, d_rdata, DATA_A5);
    end
    d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_addr_change();
    int pulses = 0;
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h0000_ABCF; block_data_out = DATA_B7;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) begin
        i_req  = 1'b0;
        i_addr = 32'hFFFF_FFFF;
      end
      tests_run++;
      if (bre !== 1'b1 || baddr !== 32'h0000_ABC0 || i_ready !== 1'b0) begin
        fails++;
        $display("FAIL addr_hold cyc %0d: re=%b addr=%h ir=%b want re=1 addr=0000abc0 ir=0",
                 c, bre, baddr, i_ready);
      end
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (i_ready === 1'b1) pulses++;
      if (c == 0) begin
        tests_run++;
        if (i_ready !== 1'b1 || d_ready !== 1'b0 || i_rdata !== DATA_B7) begin
          fails++;
          $display("FAIL addr_resp: ir=%b dr=%b i_rdata=%h want ir=1 dr=0 i_rdata=%h",
                   i_ready, d_ready, i_rdata, DATA_B7);
        end
      end
    end
    tests_run++;
    if (pulses !== 1) begin
      fails++;
      $display("FAIL addr_pulse_count: got %0d want 1", pulses);
    end
    i_addr = 32'h0;
  endtask

  task automatic test_round_robin();
    logic exp_d, exp_i;
    rst = 1'b1;
    i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    i_addr = 32'h0000_0100; d_addr = 32'h0000_0200; block_data_out = DATA_3C;
    @(negedge clk);
    rst = 1'b0;
    for (int n = 1; n <= 23; n++) begin
      @(negedge clk);
      exp_d = (n % 6 == 5) && ((n / 6) % 2 == 0);
      exp_i = (n % 6 == 5) && ((n / 6) % 2 == 1);
      tests_run++;
      if (d_ready !== exp_d || i_ready !== exp_i) begin
        fails++;
        $display("FAIL rr_ready n=%0d: dr=%b ir=%b want dr=%b ir=%b", n, d_ready, i_ready, exp_d, exp_i);
      end
      if (n % 6 == 1) begin
        tests_run++;
        if (baddr !== (((n / 6) % 2 == 0) ? 32'h0000_0200 : 32'h0000_0100)) begin
          fails++;
          $display("FAIL rr_grant n=%0d: addr=%h want %h", n, baddr,
                   (((n / 6) % 2 == 0) ? 32'h0000_0200 : 32'h0000_0100));
        end
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL rr_idle: busy=%b want 0", busy);
    end
  endtask

  task automatic test_abort();
    int pulses = 0;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_3000; block_data_out = DATA_C3;
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (busy !== 1'b0 || bre !== 1'b0 || bwe !== 1'b0 || baddr !== 32'h0 ||
        d_ready !== 1'b0 || d_rdata !== 128'h0 || i_rdata !== 128'h0) begin
      fails++;
      $display("FAIL abort_async: busy=%b re=%b we=%b addr=%h dr=%b d_rdata=%h want all 0",
               busy, bre, bwe, baddr, d_ready, d_rdata);
    end
    @(negedge clk);
    d_req = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (d_ready === 1'b1 || i_ready === 1'b1) pulses++;
    end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (d_ready === 1'b1 || i_ready === 1'b1) pulses++;
    end
    tests_run++;
    if (pulses !== 0) begin
      fails++;
      $display("FAIL abort_no_ready: got %0d pulses want 0", pulses);
    end
    d_req = 1'b1; d_addr = 32'h0000_4448; block_data_out = DATA_77;
    repeat (4) @(negedge clk);
    tests_run++;
    if (bre !== 1'b1 || baddr !== 32'h0000_4440) begin
      fails++;
      $display("FAIL abort_rerun_access: re=%b addr=%h want re=1 addr=00004440", bre, baddr);
    end
    @(negedge clk);
    tests_run++;
    if (d_ready !== 1'b1 || d_rdata !== DATA_77) begin
      fails++;
      $display("FAIL abort_rerun_resp: dr=%b d_rdata=%h want dr=1 d_rdata=%h", d_ready, d_rdata, DATA_77);
    end
    d_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_latency1();
    @(negedge clk);
    l1_i_req = 1'b1; l1_i_addr = 32'h0000_0057; l1_block_data_out = DATA_5A;
    @(negedge clk);
    tests_run++;
    if (l1_bre !== 1'b1 || l1_baddr !== 32'h0000_0050 || l1_i_ready !== 1'b0) begin
      fails++;
      $display("FAIL lat1_access: re=%b addr=%h ir=%b want re=1 addr=00000050 ir=0",
               l1_bre, l1_baddr, l1_i_ready);
    end
    @(negedge clk);
    tests_run++;
    if (l1_bre !== 1'b0 || l1_i_ready !== 1'b1 || l1_d_ready !== 1'b0 || l1_i_rdata !== DATA_5A) begin
      fails++;
      $display("FAIL lat1_resp: re=%b ir=%b dr=%b i_rdata=%h want re=0 ir=1 dr=0 i_rdata=%h",
               l1_bre, l1_i_ready, l1_d_ready, l1_i_rdata, DATA_5A);
    end
    l1_i_req = 1'b0;
    @(negedge clk);
    tests_run++;
    if (l1_i_ready !== 1'b0 || l1_busy !== 1'b0) begin
      fails++;
      $display("FAIL lat1_after: ir=%b busy=%b want ir=0 busy=0", l1_i_ready, l1_busy);
    end
  endtask

  initial begin
    rst = 1'b1;
    i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0;
    d_wdata = '0; block_data_out = '0;
    l1_i_req = 1'b0; l1_i_addr = '0; l1_block_data_out = '0;
    test_reset();
    test_read();
    test_write();
    test_addr_change();
    test_round_robin();
    test_abort();
    test_latency1();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
